// File: rtl/bsg_fifo_tracker_multi_if.sv
// ---------------------------------------------------------------------------
// bsg_fifo_tracker_multi_if
//
// Bundles the request counts and the tracker state/flag outputs of
// bsg_fifo_tracker_multi.
//   master : drives enq_cnt_i / deq_cnt_i, observes pointers, counts, flags
//   slave  : the tracker itself
// Signals:
//   enq_cnt_i  [enq_w]  elements written this cycle
//   deq_cnt_i  [deq_w]  elements read this cycle
//   wptr_r_o   [ptr_w]  registered write pointer (next slot to write)
//   rptr_r_o   [ptr_w]  registered read pointer (oldest element)
//   rptr_n_o   [ptr_w]  next-cycle read pointer (combinational)
//   count_r_o  [cnt_w]  registered occupancy
//   free_r_o   [cnt_w]  els_p - count_r_o
//   full_o / empty_o / almost_full_o / almost_empty_o : occupancy flags
//   err_o               sticky illegal-request flag
// ---------------------------------------------------------------------------
interface bsg_fifo_tracker_multi_if #(
    parameter int unsigned els_p     = 16,
    parameter int unsigned max_enq_p = 1,
    parameter int unsigned max_deq_p = 1
);
    localparam int unsigned ptr_w = $clog2(els_p);
    localparam int unsigned cnt_w = $clog2(els_p + 1);
    localparam int unsigned enq_w = $clog2(max_enq_p + 1);
    localparam int unsigned deq_w = $clog2(max_deq_p + 1);

    logic [enq_w-1:0] enq_cnt_i;
    logic [deq_w-1:0] deq_cnt_i;
    logic [ptr_w-1:0] wptr_r_o;
    logic [ptr_w-1:0] rptr_r_o;
    logic [ptr_w-1:0] rptr_n_o;
    logic [cnt_w-1:0] count_r_o;
    logic [cnt_w-1:0] free_r_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic             err_o;

    modport master (
        output enq_cnt_i, deq_cnt_i,
        input  wptr_r_o, rptr_r_o, rptr_n_o, count_r_o, free_r_o,
        input  full_o, empty_o, almost_full_o, almost_empty_o, err_o
    );

    modport slave (
        input  enq_cnt_i, deq_cnt_i,
        output wptr_r_o, rptr_r_o, rptr_n_o, count_r_o, free_r_o,
        output full_o, empty_o, almost_full_o, almost_empty_o, err_o
    );
endinterface

// File: rtl/bsg_fifo_tracker_multi.sv
// ---------------------------------------------------------------------------
// bsg_fifo_tracker_multi
//
// Pointer/occupancy tracker for a circular buffer of any depth, accepting up
// to max_enq_p pushes and max_deq_p pops per cycle. A cycle is applied only
// if both halves are legal (enough free slots for the push, enough elements
// for the pop, counts within their maxima); otherwise all state holds and the
// sticky error flag sets on the next edge.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   trk_if     request counts in, pointers / counts / flags out (slave side)
// ---------------------------------------------------------------------------
module bsg_fifo_tracker_multi #(
    parameter int unsigned els_p          = 16,
    parameter int unsigned max_enq_p      = 1,
    parameter int unsigned max_deq_p      = 1,
    parameter int unsigned afull_slack_p  = 1,
    parameter int unsigned aempty_slack_p = 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    bsg_fifo_tracker_multi_if.slave   trk_if
);
    localparam int unsigned ptr_w = $clog2(els_p);
    localparam int unsigned cnt_w = $clog2(els_p + 1);
    localparam int unsigned enq_w = $clog2(max_enq_p + 1);
    localparam int unsigned deq_w = $clog2(max_deq_p + 1);
    localparam int unsigned sum_w = ptr_w + 1;

    logic [ptr_w-1:0] wptr_q, wptr_d;
    logic [ptr_w-1:0] rptr_q, rptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [cnt_w-1:0] free_w;
    logic             enq_in_range, deq_in_range;
    logic             legal;
    logic [ptr_w-1:0] wptr_adv, rptr_adv;

    // ptr + cnt modulo els_p with one conditional subtract; the count never
    // exceeds els_p on a legal cycle, so a single subtract always suffices.
    function automatic logic [ptr_w-1:0] mod_add(input logic [ptr_w-1:0] ptr,
                                                  input logic [sum_w-1:0] cnt);
        logic [sum_w-1:0] sum;
        sum = {1'b0, ptr} + cnt;
        if (sum >= sum_w'(els_p))
            mod_add = ptr_w'(sum - sum_w'(els_p));
        else
            mod_add = sum[ptr_w-1:0];
    endfunction

    // The max-count check is only needed when the input field can encode
    // values above the configured maximum.
    if (max_enq_p == (1 << enq_w) - 1) begin : g_enq_full_range
        assign enq_in_range = 1'b1;
    end else begin : g_enq_part_range
        assign enq_in_range = (trk_if.enq_cnt_i <= enq_w'(max_enq_p));
    end

    if (max_deq_p == (1 << deq_w) - 1) begin : g_deq_full_range
        assign deq_in_range = 1'b1;
    end else begin : g_deq_part_range
        assign deq_in_range = (trk_if.deq_cnt_i <= deq_w'(max_deq_p));
    end

    assign free_w   = cnt_w'(els_p) - count_q;
    assign legal    = enq_in_range && deq_in_range
                   && (cnt_w'(trk_if.enq_cnt_i) <= free_w)
                   && (cnt_w'(trk_if.deq_cnt_i) <= count_q);
    assign wptr_adv = mod_add(wptr_q, sum_w'(trk_if.enq_cnt_i));
    assign rptr_adv = mod_add(rptr_q, sum_w'(trk_if.deq_cnt_i));

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // err is a pure sink of legality; it never feeds back into rptr_n.
        err_d   = err_q | ~legal;
        if (legal) begin
            wptr_d  = wptr_adv;
            rptr_d  = rptr_adv;
            count_d = count_q + cnt_w'(trk_if.enq_cnt_i) - cnt_w'(trk_if.deq_cnt_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign trk_if.wptr_r_o       = wptr_q;
    assign trk_if.rptr_r_o       = rptr_q;
    assign trk_if.rptr_n_o       = rptr_d;
    assign trk_if.count_r_o      = count_q;
    assign trk_if.free_r_o       = free_w;
    assign trk_if.full_o         = (count_q == cnt_w'(els_p));
    assign trk_if.empty_o        = (count_q == '0);
    assign trk_if.almost_full_o  = (32'(free_w) <= afull_slack_p);
    assign trk_if.almost_empty_o = (32'(count_q) <= aempty_slack_p);
    assign trk_if.err_o          = err_q;
endmodule

// File: tb/tb_bsg_fifo_tracker_multi.sv
// ---------------------------------------------------------------------------
// tb_bsg_fifo_tracker_multi
//
// Two trackers: A (els 6, enq<=2, deq<=3) and B (els 5, enq<=5, deq<=3).
// Each step drives both, pushes the model's expected next state into a
// per-DUT queue, and pops/compares it after the following clock edge.
// ---------------------------------------------------------------------------
module tb_bsg_fifo_tracker_multi;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int w;
        int r;
        int c;
        int err;
        int rn;
    } st_t;

    st_t sa, sb;
    st_t qa[$];
    st_t qb[$];

    bsg_fifo_tracker_multi_if #(.els_p(6), .max_enq_p(2), .max_deq_p(3)) ifa ();
    bsg_fifo_tracker_multi_if #(.els_p(5), .max_enq_p(5), .max_deq_p(3)) ifb ();

    bsg_fifo_tracker_multi #(
        .els_p(6), .max_enq_p(2), .max_deq_p(3), .afull_slack_p(1), .aempty_slack_p(1)
    ) dut_a (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .trk_if   (ifa)
    );

    bsg_fifo_tracker_multi #(
        .els_p(5), .max_enq_p(5), .max_deq_p(3), .afull_slack_p(1), .aempty_slack_p(1)
    ) dut_b (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .trk_if   (ifb)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour: whole-cycle legality, modular pointers via %.
    function automatic st_t advance(st_t s, int els, int maxe, int maxd, int enq, int deq);
        st_t n = s;
        bit  ok;
        ok = (enq <= maxe) && (deq <= maxd) && (enq <= els - s.c) && (deq <= s.c);
        n.rn = ok ? (s.r + deq) % els : s.r;
        if (ok) begin
            n.w = (s.w + enq) % els;
            n.r = n.rn;
            n.c = s.c + enq - deq;
        end else begin
            n.err = 1;
        end
        return n;
    endfunction

    task automatic check_state(string p, int els, logic [31:0] w, logic [31:0] r,
                               logic [31:0] c, logic [31:0] f, logic fu, logic em,
                               logic af, logic ae, logic er, st_t e);
        chk({p, ".wptr"},  w, e.w);
        chk({p, ".rptr"},  r, e.r);
        chk({p, ".count"}, c, e.c);
        chk({p, ".free"},  f, els - e.c);
        chk({p, ".full"},  32'(fu), 32'(e.c == els));
        chk({p, ".empty"}, 32'(em), 32'(e.c == 0));
        chk({p, ".afull"}, 32'(af), 32'((els - e.c) <= 1));
        chk({p, ".aempty"},32'(ae), 32'(e.c <= 1));
        chk({p, ".err"},   32'(er), e.err);
    endtask

    task automatic check_a(st_t e);
        check_state("A", 6, ifa.wptr_r_o, ifa.rptr_r_o, ifa.count_r_o, ifa.free_r_o,
                    ifa.full_o, ifa.empty_o, ifa.almost_full_o, ifa.almost_empty_o,
                    ifa.err_o, e);
    endtask

    task automatic check_b(st_t e);
        check_state("B", 5, ifb.wptr_r_o, ifb.rptr_r_o, ifb.count_r_o, ifb.free_r_o,
                    ifb.full_o, ifb.empty_o, ifb.almost_full_o, ifb.almost_empty_o,
                    ifb.err_o, e);
    endtask

    // One clock of traffic on both trackers.
    task automatic step(int ea, int da, int eb, int db);
        st_t na, nb;
        @(negedge clk);
        ifa.enq_cnt_i = 2'(ea);
        ifa.deq_cnt_i = 2'(da);
        ifb.enq_cnt_i = 3'(eb);
        ifb.deq_cnt_i = 2'(db);
        na = advance(sa, 6, 2, 3, ea, da);
        nb = advance(sb, 5, 5, 3, eb, db);
        #1;
        chk("A.rptr_n", 32'(ifa.rptr_n_o), na.rn);
        chk("B.rptr_n", 32'(ifb.rptr_n_o), nb.rn);
        qa.push_back(na);
        qb.push_back(nb);
        sa = na;
        sb = nb;
        @(posedge clk);
        #1;
        check_a(qa.pop_front());
        check_b(qb.pop_front());
    endtask

    // Mid-cycle asynchronous reset; A is given a nonzero dequeue request
    // during reset, which must not move rptr_n or set err.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        ifa.enq_cnt_i = '0;
        ifa.deq_cnt_i = 2'd3;
        ifb.enq_cnt_i = '0;
        ifb.deq_cnt_i = '0;
        sa = '{default: 0};
        sb = '{default: 0};
        qa.delete();
        qb.delete();
        #1;
        check_a(sa);
        check_b(sb);
        chk("RST.rptr_n", 32'(ifa.rptr_n_o), 0);
        @(posedge clk);
        #1;
        check_a(sa);
        chk("RST.rptr_n_hold", 32'(ifa.rptr_n_o), 0);
        @(negedge clk);
        ifa.deq_cnt_i = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        int eb, db;
        ifa.enq_cnt_i = '0;
        ifa.deq_cnt_i = '0;
        ifb.enq_cnt_i = '0;
        ifb.deq_cnt_i = '0;
        sa = '{default: 0};
        sb = '{default: 0};

        // Reset state
        #12;
        check_a(sa);
        check_b(sb);
        chk("RST.rptr_n_init", 32'(ifa.rptr_n_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-cycle reset from count 4
        step(2, 0, 0, 0);
        step(2, 0, 0, 0);
        chk("S1.count_before_reset", 32'(ifa.count_r_o), 4);
        do_reset();

        // Fill and wrap
        step(2, 0, 0, 0);
        step(2, 0, 0, 0);
        step(2, 0, 0, 0);
        chk("S2.full", 32'(ifa.full_o), 1);
        chk("S2.wptr_wrap", 32'(ifa.wptr_r_o), 0);
        step(0, 3, 0, 0);
        step(0, 3, 0, 0);
        chk("S2.empty", 32'(ifa.empty_o), 1);

        // Mixed traffic: reach count 3, rptr 4, wptr 1
        step(2, 0, 0, 0);
        step(2, 0, 0, 0);
        step(2, 3, 0, 0);
        step(1, 1, 0, 0);
        chk("S3.pre_count", 32'(ifa.count_r_o), 3);
        chk("S3.pre_rptr",  32'(ifa.rptr_r_o), 4);
        chk("S3.pre_wptr",  32'(ifa.wptr_r_o), 1);
        step(2, 3, 0, 0);
        chk("S3.count", 32'(ifa.count_r_o), 2);
        chk("S3.rptr",  32'(ifa.rptr_r_o), 1);
        chk("S3.wptr",  32'(ifa.wptr_r_o), 3);

        // Overflow at count 5, then err stays through legal traffic
        step(2, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("S4.pre_count", 32'(ifa.count_r_o), 5);
        step(2, 1, 0, 0);
        chk("S4.count_hold", 32'(ifa.count_r_o), 5);
        chk("S4.err", 32'(ifa.err_o), 1);
        step(0, 3, 0, 0);
        step(1, 0, 0, 0);
        chk("S4.err_sticky", 32'(ifa.err_o), 1);
        do_reset();

        // Underflow when empty
        step(0, 1, 0, 0);
        chk("S5.err", 32'(ifa.err_o), 1);
        chk("S5.count", 32'(ifa.count_r_o), 0);
        do_reset();

        // Enqueue count above max_enq_p with plenty of free slots
        step(3, 0, 0, 0);
        chk("S5.over_max_err", 32'(ifa.err_o), 1);
        chk("S5.over_max_wptr", 32'(ifa.wptr_r_o), 0);
        do_reset();

        // Non-power-of-two depth, full-depth add from wptr 3
        step(0, 0, 3, 0);
        step(0, 0, 0, 3);
        chk("S6.pre_wptr", 32'(ifb.wptr_r_o), 3);
        step(0, 0, 5, 0);
        chk("S6.wptr", 32'(ifb.wptr_r_o), 3);
        chk("S6.full", 32'(ifb.full_o), 1);

        // Random legal stream on B
        for (int i = 0; i < 10000; i++) begin
            eb = $urandom_range(((5 - sb.c) < 5 ? (5 - sb.c) : 5), 0);
            db = $urandom_range((sb.c < 3 ? sb.c : 3), 0);
            step(0, 0, eb, db);
        end
        chk("S6.no_err", 32'(ifb.err_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bsg_fifo_tracker_multi.md
# bsg_fifo_tracker_multi

Pointer and occupancy tracker for circular-buffer FIFOs of any depth. It accepts up to `max_enq_p` enqueues and `max_deq_p` dequeues per cycle. It generalises the single-enqueue/single-dequeue power-of-two tracker to:

- non-power-of-two depths;
- multi-element pushes and pops;
- explicit occupancy and free-slot counts;
- almost-full and almost-empty thresholds;
- sticky overflow/underflow error detection.

It sits beside a 1R1W memory in wide/streaming FIFOs and drives that memory's read and write addresses.

## Interface
- `els_p`, 16: number of slots; any value ≥2.
- `max_enq_p`, 1: max elements enqueued per cycle; 1..`els_p`.
- `max_deq_p`, 1: max elements dequeued per cycle; 1..`els_p`.
- `afull_slack_p`, 1: `almost_full_o` asserts when free slots ≤ this value.
- `aempty_slack_p`, 1: `almost_empty_o` asserts when occupancy ≤ this value.
- Derived widths: `ptr_w = $clog2(els_p)`, `cnt_w = $clog2(els_p+1)`, `enq_w = $clog2(max_enq_p+1)`, `deq_w = $clog2(max_deq_p+1)`.

Ports:
- `clk_i` in 1: clock. One clock; reset is asynchronous and active-low.
- `reset_n_i` in 1: asynchronous active-low reset. Assertion clears state immediately. Deassertion is synchronised externally.
- `enq_cnt_i` in `enq_w`: elements written this cycle.
- `deq_cnt_i` in `deq_w`: elements read this cycle.
- `wptr_r_o` out `ptr_w`: registered write pointer (next slot to write).
- `rptr_r_o` out `ptr_w`: registered read pointer (oldest element).
- `rptr_n_o` out `ptr_w`: next-cycle read pointer (combinational), used for synchronous-read memories.
- `count_r_o` out `cnt_w`: registered occupancy.
- `free_r_o` out `cnt_w`: `els_p` − `count_r_o`.
- `full_o`, `empty_o`, `almost_full_o`, `almost_empty_o` out 1: flags, all decoded from registered state only.
- `err_o` out 1: sticky illegal-request flag.

## Operation
- **Legality per cycle:** the cycle is legal iff `enq_cnt_i` ≤ `free_r_o` AND `deq_cnt_i` ≤ `count_r_o`.
  - No same-cycle bypass: an element enqueued this cycle cannot be dequeued this cycle, and slots freed this cycle cannot be refilled this cycle.
- **Legal cycle updates:**
  - `wptr` ← `wptr` + `enq_cnt_i` mod `els_p`.
  - `rptr` ← `rptr` + `deq_cnt_i` mod `els_p`.
  - `count` ← `count` + `enq_cnt_i` − `deq_cnt_i`.
- **Illegal cycle:** all pointer and count registers hold. `err_o` sets on the next edge and stays set until reset.
  - The enqueue and dequeue halves are never partially applied.
- **Modular add:** compute `sum = ptr + cnt` at `ptr_w`+1 bits. If `sum` ≥ `els_p`, the result is `sum` − `els_p`; otherwise `sum`. The single subtract is sufficient because `cnt` ≤ `els_p`. Never rely on natural binary wrap.
- **`rptr_n_o`:** equals the advanced `rptr` on a legal cycle, else `rptr_r_o`.
- **Flags:**
  - `full_o` = (`count_r_o` == `els_p`).
  - `empty_o` = (`count_r_o` == 0).
  - `almost_full_o` = (`free_r_o` ≤ `afull_slack_p`).
  - `almost_empty_o` = (`count_r_o` ≤ `aempty_slack_p`).
- **Zero counts:** `enq_cnt_i` = 0 and `deq_cnt_i` = 0 is a legal no-op.
- **Simultaneous enq/deq when full:** illegal if `enq_cnt_i` > 0, because `free_r_o` is 0.
- **Simultaneous enq/deq when empty:** illegal if `deq_cnt_i` > 0.
- **Counts above the maximum:** input values above `max_enq_p` or `max_deq_p` are illegal and are treated like any other illegal cycle.

## Timing
- **Reset values, asserted asynchronously:**
  - `wptr_r_o` = 0, `rptr_r_o` = 0, `count_r_o` = 0, `free_r_o` = `els_p`.
  - `empty_o` = 1, `full_o` = 0, `almost_empty_o` = 1.
  - `almost_full_o` = (`els_p` ≤ `afull_slack_p`).
  - `err_o` = 0.
- **While `reset_n_i` is low:** registers hold their reset values and `err_o` cannot set. `rptr_n_o` is 0 for any `deq_cnt_i`: a nonzero count is illegal because occupancy is 0, and a zero count leaves the pointer at 0.
- **Latency:** every registered output reflects the cycle-N request at cycle N+1. `rptr_n_o` is zero-latency combinational from `deq_cnt_i` and `enq_cnt_i` through the legality check.
- **Mid-operation reset:** takes effect without a clock edge. All in-flight state is discarded.
- **Logic depth:** the critical path is legality compare → modular add → `rptr_n_o`; it must not include `err_o`.

## Test plan
Configuration for all scenarios unless noted: `els_p`=6, `max_enq_p`=2, `max_deq_p`=3, slacks=1.

1. **Reset:** after reset, `empty_o`=1, `almost_empty_o`=1, `free_r_o`=6, both pointers 0. Assert `reset_n_i` low mid-cycle while `count`=4 → all outputs return to reset values before the next edge.
2. **Fill and wrap:** enq 2,2,2 → `wptr` 2,4,0 and `full_o`=1 after the third edge; `almost_full_o`=1 from `count`=5 onward (here it first shows at `count`=6). Then deq 3,3 → `rptr` 3,0, `empty_o`=1.
3. **Mixed traffic:** from `count`=3, `rptr`=4, `wptr`=1: apply enq 2 with deq 3 → `count`=2, `rptr`=1, `wptr`=3; `rptr_n_o`=1 during the same cycle.
4. **Overflow:** at `count`=5, apply enq 2 with deq 1 → illegal; all state holds, `err_o`=1 next cycle and stays 1 through subsequent legal traffic until reset.
5. **Underflow when empty:** deq 1 → illegal; `rptr_n_o`=`rptr_r_o`, `count` stays 0, `err_o`=1.
6. **Non-power-of-two and max-depth add:** with `els_p`=5, `max_enq_p`=5, enq 5 from `wptr`=3 → `wptr`=3, `full_o`=1. Run a 10k-cycle random legal stream checked against a reference model: `err_o` never asserts and pointer/count invariants hold.
